// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide controller.
package mdu_ctrl_pkg;

   localparam int unsigned MDU_W        = 32;
   localparam int unsigned MDU_DIV_ITER = 32;
   localparam int unsigned MDU_MUL_LAT  = 2;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } mdu_op_t;

   typedef enum logic [2:0] {
      MDU_IDLE,
      MDU_MUL,
      MDU_DIV,
      MDU_FIX,
      MDU_DONE
   } mdu_state_t;

   typedef struct packed {
      logic [MDU_W-1:0] hi;
      logic [MDU_W-1:0] lo;
   } mdu_hilo_t;

   function automatic logic op_is_div(input mdu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_acc(input mdu_op_t op);
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic op_is_sub(input mdu_op_t op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic op_signed(input mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EXE-stage <-> MDU handshake and operand/result bus.
interface mdu_ctrl_if;
   import mdu_ctrl_pkg::*;

   logic                 MDU_Start;
   mdu_op_t              MDU_Op;
   logic [MDU_W-1:0]     EXE_BusA;
   logic [MDU_W-1:0]     EXE_BusB;
   logic [2*MDU_W-1:0]   HiLo_In;
   logic                 Flush;
   logic                 MDU_Stall;
   logic                 MDU_Done;
   logic [MDU_W-1:0]     EXE_Hi;
   logic [MDU_W-1:0]     EXE_Lo;

   modport master (
      output MDU_Start, MDU_Op, EXE_BusA, EXE_BusB, HiLo_In, Flush,
      input  MDU_Stall, MDU_Done, EXE_Hi, EXE_Lo
   );

   modport slave (
      input  MDU_Start, MDU_Op, EXE_BusA, EXE_BusB, HiLo_In, Flush,
      output MDU_Stall, MDU_Done, EXE_Hi, EXE_Lo
   );

endinterface

// File: rtl/mdu_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; one quotient bit per step.
// The start cycle already performs the first step so the iteration count fits the op latency.
module mdu_div_iter
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned DIV_ITER = MDU_DIV_ITER
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start,
   input  logic                              i_en,
   input  logic [MDU_W-1:0]                  i_dividend,
   input  logic [MDU_W-1:0]                  i_divisor,
   output logic [$clog2(DIV_ITER+1)-1:0]     o_cnt,
   output logic [MDU_W-1:0]                  o_quot,
   output logic [MDU_W-1:0]                  o_rem
);

   localparam int unsigned CNT_W = $clog2(DIV_ITER + 1);

   logic [2*MDU_W-1:0] r_rem;
   logic [MDU_W-1:0]   r_dvs;
   logic [CNT_W-1:0]   r_cnt;

   // Upper half is the partial remainder, lower half shifts in quotient bits.
   function automatic logic [2*MDU_W-1:0] div_step(input logic [2*MDU_W-1:0] rem,
                                                   input logic [MDU_W-1:0]   dvs);
      logic [MDU_W:0]       w_top;
      logic [MDU_W:0]       w_diff;
      logic [2*MDU_W-1:0]   w_nxt;
      w_top  = rem[2*MDU_W-1:MDU_W-1];
      w_diff = w_top - {1'b0, dvs};
      w_nxt  = {rem[2*MDU_W-2:0], 1'b0};
      if (!w_diff[MDU_W]) begin
         w_nxt[2*MDU_W-1:MDU_W] = w_diff[MDU_W-1:0];
         w_nxt[0]               = 1'b1;
      end
      return w_nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rem <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_rem <= div_step({{MDU_W{1'b0}}, i_dividend}, i_divisor);
         r_dvs <= i_divisor;
         r_cnt <= CNT_W'(DIV_ITER - 1);
      end else if (i_en && (r_cnt != '0)) begin
         r_rem <= div_step(r_rem, r_dvs);
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_quot = r_rem[MDU_W-1:0];
   assign o_rem  = r_rem[2*MDU_W-1:MDU_W];

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide sequencer: inline multiplier, iterative divider, flush abort.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned DIV_ITER = MDU_DIV_ITER,
   parameter int unsigned MUL_LAT  = MDU_MUL_LAT
) (
   input  logic        clk,
   input  logic        rst,
   mdu_ctrl_if.slave   bus
);

   localparam int unsigned W      = MDU_W;
   localparam int unsigned MCNT_W = $clog2(MUL_LAT + 1);
   localparam int unsigned DCNT_W = $clog2(DIV_ITER + 1);

   mdu_state_t          r_state, w_state_nxt;
   mdu_op_t             r_op, w_src_op;
   logic [W-1:0]        r_a, r_b, w_src_a, w_src_b;
   logic [MCNT_W-1:0]   r_cnt, w_cnt_nxt;
   mdu_hilo_t           r_res, r_prev;

   logic                w_op_ok, w_latch, w_dz_wr, w_mul_wr, w_fix_wr, w_restore;
   logic                w_div_start, w_div_en, w_stall, w_done;
   logic                w_ext_a, w_ext_b;
   logic [2*W-1:0]      w_ma, w_mb, w_prod, w_mul_res;
   logic                w_sgn_in, w_fix_sgn;
   logic [W-1:0]        w_abs_a, w_abs_b, w_quot, w_rem, w_q_fix, w_r_fix;
   logic [DCNT_W-1:0]   w_div_cnt;

   // With MUL_LAT == 1 the product is taken straight from the bus in the start cycle.
   assign w_src_op = (r_state == MDU_IDLE) ? bus.MDU_Op   : r_op;
   assign w_src_a  = (r_state == MDU_IDLE) ? bus.EXE_BusA : r_a;
   assign w_src_b  = (r_state == MDU_IDLE) ? bus.EXE_BusB : r_b;

   always_comb begin
      w_ext_a = op_signed(w_src_op) & w_src_a[W-1];
      w_ext_b = op_signed(w_src_op) & w_src_b[W-1];
      w_ma    = {{W{w_ext_a}}, w_src_a};
      w_mb    = {{W{w_ext_b}}, w_src_b};
      w_prod  = w_ma * w_mb;
   end

`ifdef MDU_MADD_EN
   logic [2*W-1:0] r_hilo, w_src_hilo;

   assign w_src_hilo = (r_state == MDU_IDLE) ? bus.HiLo_In : r_hilo;
   assign w_op_ok    = 1'b1;

   always_comb begin
      w_mul_res = w_prod;
      if (op_is_acc(w_src_op)) begin
         w_mul_res = op_is_sub(w_src_op) ? (w_src_hilo - w_prod) : (w_src_hilo + w_prod);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hilo <= '0;
      end else if (w_latch) begin
         r_hilo <= bus.HiLo_In;
      end
   end
`else
   assign w_op_ok   = !op_is_acc(bus.MDU_Op);
   assign w_mul_res = w_prod;
`endif

   // Divider runs on magnitudes; FIX restores signs afterwards.
   assign w_sgn_in = op_signed(bus.MDU_Op);
   assign w_abs_a  = (w_sgn_in && bus.EXE_BusA[W-1]) ? -bus.EXE_BusA : bus.EXE_BusA;
   assign w_abs_b  = (w_sgn_in && bus.EXE_BusB[W-1]) ? -bus.EXE_BusB : bus.EXE_BusB;

   mdu_div_iter #(
      .DIV_ITER (DIV_ITER)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_start    (w_div_start),
      .i_en       (w_div_en),
      .i_dividend (w_abs_a),
      .i_divisor  (w_abs_b),
      .o_cnt      (w_div_cnt),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   assign w_fix_sgn = op_signed(r_op);
   assign w_q_fix   = (w_fix_sgn && (r_a[W-1] ^ r_b[W-1])) ? -w_quot : w_quot;
   assign w_r_fix   = (w_fix_sgn && r_a[W-1]) ? -w_rem : w_rem;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= MDU_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      w_latch     = 1'b0;
      w_dz_wr     = 1'b0;
      w_mul_wr    = 1'b0;
      w_fix_wr    = 1'b0;
      w_restore   = 1'b0;
      w_div_start = 1'b0;
      w_div_en    = 1'b0;
      case (r_state)
         MDU_IDLE: begin
            if (bus.MDU_Start && !bus.Flush && w_op_ok) begin
               w_stall = 1'b1;
               w_latch = 1'b1;
               if (op_is_div(bus.MDU_Op)) begin
                  if (bus.EXE_BusB == '0) begin
                     w_dz_wr     = 1'b1;
                     w_state_nxt = MDU_DONE;
                  end else begin
                     w_div_start = 1'b1;
                     w_state_nxt = (DIV_ITER > 1) ? MDU_DIV : MDU_FIX;
                  end
               end else begin
                  w_cnt_nxt = MCNT_W'(MUL_LAT - 1);
                  if (MUL_LAT == 1) begin
                     w_mul_wr    = 1'b1;
                     w_state_nxt = MDU_DONE;
                  end else begin
                     w_state_nxt = MDU_MUL;
                  end
               end
            end
         end
         MDU_MUL: begin
            w_stall = 1'b1;
            if (bus.Flush) begin
               w_state_nxt = MDU_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - MCNT_W'(1);
               if (r_cnt <= MCNT_W'(1)) begin
                  w_mul_wr    = 1'b1;
                  w_state_nxt = MDU_DONE;
               end
            end
         end
         MDU_DIV: begin
            w_stall = 1'b1;
            if (bus.Flush) begin
               w_state_nxt = MDU_IDLE;
            end else begin
               w_div_en = 1'b1;
               if (w_div_cnt <= DCNT_W'(1)) begin
                  w_state_nxt = MDU_FIX;
               end
            end
         end
         MDU_FIX: begin
            w_stall = 1'b1;
            if (bus.Flush) begin
               w_state_nxt = MDU_IDLE;
            end else begin
               w_fix_wr    = 1'b1;
               w_state_nxt = MDU_DONE;
            end
         end
         MDU_DONE: begin
            w_state_nxt = MDU_IDLE;
            if (bus.Flush) begin
               w_restore = 1'b1;
            end else begin
               w_done = 1'b1;
            end
         end
         default: begin
            w_state_nxt = MDU_IDLE;
         end
      endcase
   end

   // r_prev lets a flush in the DONE cycle undo the already-written result.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op   <= OP_MULT;
         r_a    <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
         r_res  <= '0;
         r_prev <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_latch) begin
            r_op   <= bus.MDU_Op;
            r_a    <= bus.EXE_BusA;
            r_b    <= bus.EXE_BusB;
            r_prev <= r_res;
         end
         if (w_dz_wr) begin
            r_res <= {bus.EXE_BusA, {W{1'b1}}};
         end else if (w_mul_wr) begin
            r_res <= w_mul_res;
         end else if (w_fix_wr) begin
            r_res <= {w_r_fix, w_q_fix};
         end else if (w_restore) begin
            r_res <= r_prev;
         end
      end
   end

   assign bus.MDU_Stall = w_stall;
   assign bus.MDU_Done  = w_done;
   assign bus.EXE_Hi    = r_res.hi;
   assign bus.EXE_Lo    = r_res.lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: cycle-level reference model plus directed vectors with literal results.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mdu_ctrl_if u_if();

   mdu_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   int n_run  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_ok(input mdu_op_t op);
`ifdef MDU_MADD_EN
      return 1'b1;
`else
      return !(op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`endif
   endfunction

   function automatic int ref_lat(input mdu_op_t op, input logic [31:0] b);
      if (op == OP_DIV || op == OP_DIVU) return (b == 32'd0) ? 1 : 33;
      return 2;
   endfunction

   function automatic logic [63:0] ref_res(input mdu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
      longint          sp;
      longint unsigned up;
      int              sa, sb, q, r;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = {32'd0, a} * {32'd0, b};
      case (op)
         OP_MULT:  return sp;
         OP_MULTU: return up;
         OP_MADD:  return hilo + sp;
         OP_MADDU: return hilo + up;
         OP_MSUB:  return hilo - sp;
         OP_MSUBU: return hilo - up;
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
         end
      endcase
   endfunction

   // Reference model: tracks cycles since start and the architecturally visible HI/LO.
   logic        m_act = 1'b0;
   int          m_k, m_lat;
   logic [63:0] m_cur = '0;
   logic [63:0] m_new;
   logic        e_stall;

   always @(negedge clk) begin
      if (!rst) begin
         m_act = 1'b0;
         m_cur = '0;
      end else if (chk_en) begin
         if (!m_act) begin
            e_stall = u_if.MDU_Start && !u_if.Flush && ref_ok(u_if.MDU_Op);
            chk("idle stall", u_if.MDU_Stall, e_stall);
            chk("idle done", u_if.MDU_Done, 1'b0);
            chk("idle hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, m_cur);
            if (e_stall) begin
               m_act = 1'b1;
               m_k   = 0;
               m_lat = ref_lat(u_if.MDU_Op, u_if.EXE_BusB);
               m_new = ref_res(u_if.MDU_Op, u_if.EXE_BusA, u_if.EXE_BusB, u_if.HiLo_In);
            end
         end else begin
            m_k++;
            if (m_k < m_lat) begin
               chk("busy stall", u_if.MDU_Stall, 1'b1);
               chk("busy done", u_if.MDU_Done, 1'b0);
               chk("busy hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, m_cur);
               if (u_if.Flush) m_act = 1'b0;
            end else begin
               chk("done stall", u_if.MDU_Stall, 1'b0);
               chk("done pulse", u_if.MDU_Done, !u_if.Flush);
               if (!u_if.Flush) begin
                  chk("done hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, m_new);
                  m_cur = m_new;
               end
               m_act = 1'b0;
            end
         end
      end
   end

   // Issue one op; flush_at < 0 means no flush. exp_lat == 0 means no Done is expected.
   task automatic do_op(input string name, input mdu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input int flush_at,
                        input int exp_lat, input logic [63:0] exp_res);
      int cyc;
      bit got;
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b1;
      u_if.MDU_Op    = op;
      u_if.EXE_BusA  = a;
      u_if.EXE_BusB  = b;
      u_if.HiLo_In   = hilo;
      u_if.Flush     = (flush_at == 0);
      cyc = 0;
      got = 1'b0;
      @(negedge clk);
      while (!got && cyc < 60) begin
         @(posedge clk); #1;
         u_if.MDU_Start = 1'b0;
         cyc++;
         u_if.Flush = (cyc == flush_at);
         @(negedge clk);
         if (u_if.MDU_Done) got = 1'b1;
      end
      chk({name, " lat"}, got ? 64'(cyc) : 64'd0, 64'(exp_lat));
      chk({name, " res"}, {u_if.EXE_Hi, u_if.EXE_Lo}, exp_res);
      @(posedge clk); #1;
      u_if.Flush = 1'b0;
   endtask

   initial begin
      u_if.MDU_Start = 1'b0;
      u_if.MDU_Op    = OP_MULT;
      u_if.EXE_BusA  = '0;
      u_if.EXE_BusB  = '0;
      u_if.HiLo_In   = '0;
      u_if.Flush     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst stall", u_if.MDU_Stall, 1'b0);
      chk("rst done", u_if.MDU_Done, 1'b0);
      chk("rst hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, 64'd0);

      do_op("mult -2*3",     OP_MULT,  32'hFFFF_FFFE, 32'd3,         '0, -1, 2,  64'hFFFF_FFFF_FFFF_FFFA);
      do_op("divu 100/7",    OP_DIVU,  32'd100,       32'd7,         '0, -1, 33, 64'h0000_0002_0000_000E);
      do_op("div -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         '0, -1, 33, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op("div min/-1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '0, -1, 33, 64'h0000_0000_8000_0000);
      do_op("div 5/0",       OP_DIV,   32'd5,         32'd0,         '0, -1, 1,  64'h0000_0005_FFFF_FFFF);
      do_op("divu max/max-1",OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFE, '0, -1, 33, 64'h0000_0001_0000_0001);
      do_op("divu 7/max",    OP_DIVU,  32'd7,         32'hFFFF_FFFF, '0, -1, 33, 64'h0000_0007_0000_0000);
      do_op("div 7/-2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, '0, -1, 33, 64'h0000_0001_FFFF_FFFD);
      do_op("multu max^2",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, -1, 2,  64'hFFFF_FFFE_0000_0001);
      do_op("mult min^2",    OP_MULT,  32'h8000_0000, 32'h8000_0000, '0, -1, 2,  64'h4000_0000_0000_0000);
      do_op("divu flush@10", OP_DIVU,  32'd1000,      32'd3,         '0, 10, 0,  64'h4000_0000_0000_0000);
      do_op("multu 3*4",     OP_MULTU, 32'd3,         32'd4,         '0, -1, 2,  64'h0000_0000_0000_000C);
      do_op("dz flush@done", OP_DIV,   32'd5,         32'd0,         '0, 1,  0,  64'h0000_0000_0000_000C);
      do_op("flush@start",   OP_MULT,  32'd2,         32'd2,         '0, 0,  0,  64'h0000_0000_0000_000C);

      // Start raised in the DONE cycle must not launch a new op.
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b1; u_if.MDU_Op = OP_MULTU; u_if.EXE_BusA = 32'd2; u_if.EXE_BusB = 32'd3;
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b0;
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b1; u_if.MDU_Op = OP_DIVU; u_if.EXE_BusA = 32'd9; u_if.EXE_BusB = 32'd2;
      @(negedge clk);
      chk("sid done", u_if.MDU_Done, 1'b1);
      chk("sid hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, 64'd6);
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b0;
      @(negedge clk);
      chk("sid ignored stall", u_if.MDU_Stall, 1'b0);

`ifdef MDU_MADD_EN
      do_op("maddu carry",   OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, -1, 2, 64'h0000_0002_0000_0000);
      do_op("msub 0-1",      OP_MSUB,  32'd1, 32'd1, 64'd0,                   -1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op("madd 10+-2",    OP_MADD,  32'hFFFF_FFFF, 32'd2, 64'd10,          -1, 2, 64'h0000_0000_0000_0008);
      do_op("msubu",         OP_MSUBU, 32'hFFFF_FFFF, 32'd2, 64'd0,           -1, 2, 64'hFFFF_FFFE_0000_0002);
`else
      do_op("madd reserved", OP_MADD,  32'd1, 32'd1, 64'd5, -1, 0, 64'h0000_0000_0000_0006);
      do_op("msubu reserved",OP_MSUBU, 32'd1, 32'd1, 64'd5, -1, 0, 64'h0000_0000_0000_0006);
`endif

      // Reset in the middle of a divide clears everything.
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b1; u_if.MDU_Op = OP_DIVU; u_if.EXE_BusA = 32'd100; u_if.EXE_BusB = 32'd7;
      @(posedge clk); #1;
      u_if.MDU_Start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst stall", u_if.MDU_Stall, 1'b0);
      chk("midrst done", u_if.MDU_Done, 1'b0);
      chk("midrst hilo", {u_if.EXE_Hi, u_if.EXE_Lo}, 64'd0);

      do_op("post-rst div",  OP_DIV,   32'hFFFF_FF9C, 32'd7, '0, -1, 33, 64'hFFFF_FFFE_FFFF_FFF2);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1, "watchdog");
   end

endmodule
